// File: rtl/avalon_mm_burst_slave.sv
// Avalon-MM on-chip RAM responder with fixed wait states, fixed read
// latency pipeline and incrementing burst reads.
module avalon_mm_burst_slave #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WAITSTATES  = 0,
  parameter int READLATENCY = 2,
  parameter int MAXBURST    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    address,
  input  logic [NBDATABYTES-1:0]   byteenable,
  input  logic [8*NBDATABYTES-1:0] writedata,
  input  logic                     read,
  input  logic                     write,
  input  logic [7:0]               burstcount,
  input  logic                     beginbursttransfer,
  output logic [8*NBDATABYTES-1:0] readdata,
  output logic                     readdatavalid,
  output logic                     waitrequest
);

  localparam int DW    = 8 * NBDATABYTES;
  localparam int DEPTH = 2 ** NBADDRBITS;

  // Wait counter start value; unused when the slave has no wait states.
  localparam logic [3:0] WAIT_LOAD = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;
  localparam logic [7:0] MAX_B     = 8'(MAXBURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [NBADDRBITS-1:0]   burst_addr, burst_addr_nxt;
  logic [7:0]              beats_left, beats_left_nxt;
  logic [7:0]              burst_len;
  logic                    wait_req;
  logic                    accept;
  logic                    mem_we;
  logic                    issue_valid;
  logic [NBADDRBITS-1:0]   issue_addr;
  logic [DW-1:0]           issue_data;

  logic [DW-1:0]           mem [DEPTH];

  logic [READLATENCY-1:0]  vld_pipe;
  logic [DW-1:0]           dat_pipe [READLATENCY];

  // The burst marker carries no information this slave needs.
  logic unused_bbt;
  assign unused_bbt = beginbursttransfer;

  // Effective burst length: 0 means one beat, oversize requests are clamped.
  always_comb begin
    burst_len = burstcount;
    if (burstcount == 8'd0)
      burst_len = 8'd1;
    else if (burstcount > MAX_B)
      burst_len = MAX_B;
  end

  // Next-state, handshake and beat-issue decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt      = state;
    cnt_nxt        = cnt;
    burst_addr_nxt = burst_addr;
    beats_left_nxt = beats_left;
    wait_req       = 1'b1;
    accept         = 1'b0;
    issue_valid    = 1'b0;
    issue_addr     = address;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (WAITSTATES == 0) begin
            wait_req = 1'b0;
            accept   = read | write;
          end else if (read | write) begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!(read | write)) begin
            // Master abandoned the stalled command: nothing happens.
            state_nxt = ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            wait_req = 1'b0;
            accept   = 1'b1;
          end
        end
        ST_BURST: begin
          issue_valid    = 1'b1;
          issue_addr     = burst_addr;
          burst_addr_nxt = burst_addr + NBADDRBITS'(1);
          beats_left_nxt = beats_left - 8'd1;
          if (beats_left == 8'd1)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase

      if (accept) begin
        state_nxt = ST_IDLE;
        // A write wins when read and write arrive together.
        if (!write) begin
          issue_valid = 1'b1;
          if (burst_len != 8'd1) begin
            state_nxt      = ST_BURST;
            burst_addr_nxt = address + NBADDRBITS'(1);
            beats_left_nxt = burst_len - 8'd1;
          end
        end
      end
    end
  end

  assign waitrequest = wait_req;
  assign mem_we      = accept & write;
  assign issue_data  = mem[issue_addr];

  // FSM, wait counter and burst address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      burst_addr <= '0;
      beats_left <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      burst_addr <= burst_addr_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  // Byte-lane RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset so it maps onto memory macros.
    for (int i = 0; i < NBDATABYTES; i++) begin
      if (mem_we && byteenable[i])
        mem[address][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // Fixed-latency read pipeline; the last stage holds its data between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < READLATENCY; k++)
        dat_pipe[k] <= '0;
    end else begin
      vld_pipe[0] <= issue_valid;
      if (READLATENCY > 1 || issue_valid)
        dat_pipe[0] <= issue_data;
      for (int k = 1; k < READLATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (k < READLATENCY - 1 || vld_pipe[k-1])
          dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign readdata      = dat_pipe[READLATENCY-1];
  assign readdatavalid = vld_pipe[READLATENCY-1];

endmodule

// File: doc/avalon_mm_burst_slave.md
Name: avalon_mm_burst_slave

Overview:
- Avalon-MM responder: on-chip RAM slave driving waitrequest, readdata and readdatavalid to a master.
- Supports fixed wait states, pipelined reads with fixed latency, and burst reads.
- Sits on the slave side of the bus monitored by the team's Avalon assertion checker. It is the DUT-side counterpart used to exercise the simple-wait, pipeline and burst modes.

Parameters:
NBDATABYTES, 2, data width in bytes (data bus = 8*NBDATABYTES bits)
NBADDRBITS, 8, word address width; RAM depth = 2^NBADDRBITS words
WAITSTATES, 0, wait cycles inserted before each command accepted from IDLE (0..15)
READLATENCY, 2, cycles from read-beat issue to readdatavalid (1..4)
MAXBURST, 8, largest legal burstcount (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
address  in  NBADDRBITS  word address
byteenable  in  NBDATABYTES  write byte lanes
writedata  in  8*NBDATABYTES  write data
read  in  1  read request
write  in  1  write request
burstcount  in  8  read burst length
beginbursttransfer  in  1  burst start marker (informational, not required for operation)
readdata  out  8*NBDATABYTES  read data
readdatavalid  out  1  readdata valid
waitrequest  out  1  command stall

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; readdatavalid=0; readdata=0; latency pipeline cleared; waitrequest=1 while rst high.
- RAM contents are not reset.
- A command is accepted in a cycle where (read|write) && !waitrequest.
- States and transitions:
  - IDLE: if read|write and WAITSTATES>0, waitrequest=1 combinationally, load cnt=WAITSTATES-1, go to WAIT.
  - IDLE: if WAITSTATES=0, waitrequest=0 and the command is accepted this cycle.
  - WAIT: waitrequest=1 while cnt!=0, cnt decrements each cycle. At cnt=0, waitrequest=0 and the command is accepted.
  - WAIT: if master drops read/write, return to IDLE (protocol violation, no side effects).
  - After a write accept or single-beat read accept: return to (or stay in) IDLE.
  - After a read accept with burst length B>1: go to BURST.
  - BURST: waitrequest=1. Issues one beat per cycle at addresses A+1..A+B-1, wrapping modulo 2^NBADDRBITS, then returns to IDLE.
- Write: on accept, RAM[address] byte lane i is updated iff byteenable[i]. burstcount is ignored; writes are single-beat.
- Read beat issue: RAM read at the issue address enters the latency pipeline. readdatavalid=1 with that word exactly READLATENCY cycles later.
- Burst beats return in address order, one per cycle, contiguous.
- Burst length B: burstcount==0 is treated as 1; burstcount>MAXBURST is clamped to MAXBURST. The beats-left counter is 8 bits.
- read && write together: treated as write only; no readdatavalid is generated.
- Read-after-write: a write accepted at cycle t is visible to a read beat issued at t+1 or later.
- Pipelining: with WAITSTATES=0, single reads may be accepted every cycle, giving back-to-back readdatavalid.
- readdata holds its last value when readdatavalid=0.
- Reset mid-burst or with beats in flight: all pending beats are dropped. readdatavalid=0 from reset assertion; no stale beats after release.
- Invariant: total readdatavalid beats == sum of B over accepted reads.

Test Plan:
- WAITSTATES=0, READLATENCY=2: write 0xBEEF@0x10 with byteenable=11, then read 0x10 → readdatavalid exactly 2 cycles after read accept, readdata=0xBEEF.
- Write 0x1234@0x20, then write 0xAB00@0x20 with byteenable=10, then read 0x20 → 0xAB34.
- WAITSTATES=3: read held asserted → waitrequest high 3 cycles, accept on 4th; address, read and byteenable must stay stable while stalled.
- Burst read address 0xFE, burstcount=4, RAM preloaded → beats from 0xFE,0xFF,0x00,0x01 on 4 consecutive readdatavalid cycles; waitrequest high for 3 cycles after accept. Separately, burstcount=0 → exactly 1 beat.
- WAITSTATES=0: 4 back-to-back single reads at 0..3 → 4 consecutive readdatavalid cycles with matching data, starting READLATENCY cycles after the first accept.
- Assert rst during the 2nd beat of an 8-beat burst → readdatavalid=0 immediately; state IDLE; no further beats after release; waitrequest=0 on the first idle cycle after release (WAITSTATES=0).
